dog_stage: RTL and testbench
============================

// Module: dog_stage
// PURPOSE
//  Parametrised difference-of-Gaussian stage for one scale-space octave level.
//  - Inputs: base level k, and blur level k+1 from an external Gaussian core of fixed latency.
//  - Delays base by ALIGN_DELAY accepted samples, then computes base_d - blur + OFFSET (saturation optional).
//  - Result goes to an internal FWFT FIFO with ready/valid drain toward the up-sampler / extrema detector.
// PARAMETERS
//  DATA_W      8    pixel width (base, blur, output)
//  ALIGN_DELAY 806  base-to-blur alignment, in accepted samples; >= 1
//  OFFSET      128  bias added to the difference; 0 <= OFFSET < 2**DATA_W
//  FIFO_DEPTH  16   output FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1                    clock, all logic on rising edge
//  rst        in   1                    synchronous, active-high reset
//  in_valid   in   1                    base_din/blur_din valid this cycle (no backpressure)
//  base_din   in   DATA_W               level-k pixel, unsigned
//  blur_din   in   DATA_W               level-k+1 pixel, unsigned
//  out_valid  out  1                    out_data valid (FIFO not empty)
//  out_data   out  DATA_W               DoG pixel, FIFO head
//  out_ready  in   1                    consumer pops head when out_valid & out_ready
//  fifo_count out  $clog2(FIFO_DEPTH)+1 entries held
//  primed     out  1                    delay line filled; results now produced
//  overflow   out  1                    sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: out_valid=0, fifo_count=0, primed=0, overflow=0, out_data=0.
//   Delay RAM, pointers and prime counter cleared; reset mid-stream discards all contents.
//  Delay line: circular RAM, ALIGN_DELAY x DATA_W; write pointer advances only on in_valid.
//   base_d = base_din from ALIGN_DELAY accepted samples earlier.
//   in_valid=0 cycles freeze the delay line, counters and pipe (clock-enable semantics).
//  Prime counter: 0..ALIGN_DELAY, +1 per in_valid while < ALIGN_DELAY; saturates there.
//   primed = (count == ALIGN_DELAY).
//   Samples accepted while primed=0 are consumed but produce no result.
//   Exactly ALIGN_DELAY leading samples per reset are dropped.
//  Arithmetic: d = base_d - blur_din + OFFSET, evaluated at DATA_W+2 bits signed.
//   Registered in one pipe stage; valid bit = in_valid & primed.
//  Latency: sample accepted at cycle t -> FIFO push at t+1 -> out_valid high at t+2 if FIFO was empty.
//  FIFO: FWFT; out_valid = (fifo_count != 0).
//   Pop: out_valid & out_ready. Push: pipe valid. Pointers wrap modulo FIFO_DEPTH.
//   Push & pop same cycle: both happen, count unchanged, including when full.
//   Pop while empty: ignored.
//   Push while full and no pop: result dropped, overflow <= 1; it stays 1 until rst.
//   FIFO contents are unaffected by the overflow.
// CONFIGURATION
//  DOG_SAT_EN defined: d clamped to [0, 2**DATA_W-1].
//  DOG_SAT_EN undefined: out = d[DATA_W-1:0] (wraps modulo 2**DATA_W, legacy behaviour).
// TESTING (DATA_W=8, ALIGN_DELAY=4, OFFSET=128, FIFO_DEPTH=4 unless noted)
//  1 Prime: rst, then 6 valid samples base=10,20..60, blur=0.
//    -> primed=1 after 4th sample; 2 results 138,148; out_valid first at t+2 of sample 5.
//  2 Gaps: same stream with in_valid=0 on alternate cycles.
//    -> identical output values and order as test 1, no extra/dropped results.
//  3 Arithmetic: base_d=250, blur=10 -> 255 (SAT_EN) / 112 (no SAT_EN).
//    base_d=0, blur=200 -> 0 (SAT_EN) / 184 (no SAT_EN). base_d=blur=77 -> 128 both.
//  4 Overflow: out_ready=0, primed, push 5 results.
//    -> fifo_count=4, overflow=1 on 5th push, head = 1st result.
//    Drain -> first 4 values in order, overflow stays 1.
//  5 Full + simultaneous: FIFO full, out_ready=1 with a push same cycle.
//    -> count stays 4, overflow stays 0, new value appears last.
//  6 Reset mid-operation: rst for 1 cycle with FIFO holding 3 and primed=1.
//    -> next cycle out_valid=0, fifo_count=0, primed=0, overflow=0; next 4 samples dropped again.

Source files
------------

// File: rtl/dog_stage.sv
// Difference-of-Gaussian stage: aligns the base level against the blurred level,
// subtracts with a bias and queues results in an FWFT FIFO. `DOG_SAT_EN clamps the result.
module dog_stage #(
   parameter int DATA_W      = 8,
   parameter int ALIGN_DELAY = 806,
   parameter int OFFSET      = 128,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [DATA_W-1:0]               base_din,
   input  logic [DATA_W-1:0]               blur_din,
   output logic                            out_valid,
   output logic [DATA_W-1:0]               out_data,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            primed,
   output logic                            overflow
);

   localparam int DAW = (ALIGN_DELAY > 1) ? $clog2(ALIGN_DELAY) : 1;
   localparam int PCW = $clog2(ALIGN_DELAY + 1);
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int CW  = FAW + 1;

   function automatic logic [DATA_W-1:0] sat_dog(input logic signed [DATA_W+1:0] d);
`ifdef DOG_SAT_EN
      if (d < 0)
         return '0;
      else if (d > $signed({2'b00, {DATA_W{1'b1}}}))
         return '1;
      else
         return DATA_W'(d);
`else
      return DATA_W'(d);
`endif
   endfunction

   logic [DATA_W-1:0]        r_dly_mem [ALIGN_DELAY];
   logic [DAW-1:0]           r_dly_ptr;
   logic [PCW-1:0]           r_prime_cnt;
   logic                     w_primed;
   logic [DATA_W-1:0]        w_base_d;
   logic signed [DATA_W+1:0] w_diff_p0;

   assign w_primed = (r_prime_cnt == PCW'(ALIGN_DELAY));
   assign w_base_d = r_dly_mem[r_dly_ptr];

   // Stage p0: circular delay line; the slot about to be overwritten holds the aligned base
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dly_ptr   <= '0;
         r_prime_cnt <= '0;
         for (int i = 0; i < ALIGN_DELAY; i++)
            r_dly_mem[i] <= '0;
      end else if (in_valid) begin
         r_dly_mem[r_dly_ptr] <= base_din;
         if (r_dly_ptr == DAW'(ALIGN_DELAY - 1))
            r_dly_ptr <= '0;
         else
            r_dly_ptr <= r_dly_ptr + 1'b1;
         if (!w_primed)
            r_prime_cnt <= r_prime_cnt + 1'b1;
      end
   end

   assign w_diff_p0 = $signed({2'b00, w_base_d}) - $signed({2'b00, blur_din})
                    + $signed((DATA_W+2)'(OFFSET));

   // Stage p1: registered difference; valid is a single-cycle pulse per accepted sample
   logic [DATA_W-1:0] r_dog_p1;
   logic              r_vld_p1;

   always_ff @(posedge clk) begin
      if (rst)
         r_vld_p1 <= 1'b0;
      else
         r_vld_p1 <= in_valid & w_primed;
   end

   always_ff @(posedge clk) begin
      if (in_valid)
         r_dog_p1 <= sat_dog(w_diff_p0);
   end

   // Stage p2: FWFT output FIFO
   logic [DATA_W-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [FAW-1:0]    r_wr_ptr;
   logic [FAW-1:0]    r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              w_full;
   logic              w_pop;
   logic              w_push;

   assign out_valid = (r_count != '0);
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_pop     = out_valid & out_ready;
   // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr)
   assign w_push    = r_vld_p1 & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo_mem[r_wr_ptr] <= r_dog_p1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (r_vld_p1 && w_full && !w_pop)
            r_overflow <= 1'b1;
      end
   end

   assign out_data   = out_valid ? r_fifo_mem[r_rd_ptr] : '0;
   assign fifo_count = r_count;
   assign primed     = w_primed;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_dog_stage.sv
// Directed bench for dog_stage with ALIGN_DELAY=4, FIFO_DEPTH=4.
module tb_dog_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] base_din = '0;
   logic [7:0] blur_din = '0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic [2:0] fifo_count;
   logic       primed;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   dog_stage #(
      .DATA_W      (8),
      .ALIGN_DELAY (4),
      .OFFSET      (128),
      .FIFO_DEPTH  (4)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .base_din   (base_din),
      .blur_din   (blur_din),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .primed     (primed),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick(1);
      rst      = 1'b0;
   endtask

   task automatic send(input int base, input int blur);
      base_din = 8'(base);
      blur_din = 8'(blur);
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int exp);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick(1);
         n++;
      end
      if (!out_valid)
         chk({tag, "_timeout"}, 0, 1);
      else
         chk(tag, int'(out_data), exp);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_count"}, int'(fifo_count), 0);
      chk({tag, "_primed"}, int'(primed), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_out_data"}, int'(out_data), 0);
   endtask

   int exp_a, exp_b;

   initial begin
      // Test 1: priming and first-result latency
      do_reset();
      check_reset_state("t1_rst");
      for (int i = 1; i <= 3; i++) send(10 * i, 0);
      chk("t1_primed_after3", int'(primed), 0);
      send(40, 0);
      chk("t1_primed_after4", int'(primed), 1);
      chk("t1_no_output_yet", int'(out_valid), 0);
      send(50, 0);
      chk("t1_vld_t1", int'(out_valid), 0);
      send(60, 0);
      chk("t1_vld_t2", int'(out_valid), 1);
      chk("t1_count_t2", int'(fifo_count), 1);
      tick(1);
      chk("t1_count_final", int'(fifo_count), 2);
      drain("t1_r0", 138);
      drain("t1_r1", 148);
      chk("t1_empty", int'(fifo_count), 0);

      // Test 2: same stream with idle cycles between samples
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         send(10 * i, 0);
         tick(1);
      end
      tick(2);
      chk("t2_count", int'(fifo_count), 2);
      drain("t2_r0", 138);
      drain("t2_r1", 148);
      chk("t2_empty", int'(fifo_count), 0);

      // Test 3: arithmetic corners
      do_reset();
      send(250, 0);
      send(0, 0);
      send(77, 0);
      send(0, 0);
      send(0, 10);
      send(0, 200);
      send(0, 77);
      tick(2);
`ifdef DOG_SAT_EN
      exp_a = 255;
      exp_b = 0;
`else
      exp_a = 112;
      exp_b = 184;
`endif
      drain("t3_pos", exp_a);
      drain("t3_neg", exp_b);
      drain("t3_zero", 128);

      // Test 4: overflow with consumer stalled
      do_reset();
      for (int i = 1; i <= 9; i++) send(i, 0);
      chk("t4_ovf_before", int'(overflow), 0);
      chk("t4_count_before", int'(fifo_count), 4);
      tick(1);
      chk("t4_count_full", int'(fifo_count), 4);
      chk("t4_ovf_set", int'(overflow), 1);
      chk("t4_head", int'(out_data), 129);
      for (int i = 0; i < 4; i++) drain("t4_drain", 129 + i);
      chk("t4_empty", int'(fifo_count), 0);
      chk("t4_ovf_sticky", int'(overflow), 1);

      // Test 5: push and pop together while full
      do_reset();
      for (int i = 1; i <= 9; i++) send(i, 0);
      chk("t5_full", int'(fifo_count), 4);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("t5_count", int'(fifo_count), 4);
      chk("t5_ovf", int'(overflow), 0);
      chk("t5_head", int'(out_data), 130);
      for (int i = 0; i < 4; i++) drain("t5_drain", 130 + i);
      chk("t5_empty", int'(fifo_count), 0);

      // Test 6: reset mid-operation
      do_reset();
      for (int i = 1; i <= 7; i++) send(i, 0);
      tick(1);
      chk("t6_count_pre", int'(fifo_count), 3);
      chk("t6_primed_pre", int'(primed), 1);
      do_reset();
      check_reset_state("t6_rst");
      for (int i = 0; i < 4; i++) send(20 + i, 0);
      tick(2);
      chk("t6_dropped", int'(fifo_count), 0);
      chk("t6_reprimed", int'(primed), 1);
      send(99, 0);
      tick(1);
      chk("t6_count_post", int'(fifo_count), 1);
      chk("t6_first_post", int'(out_data), 148);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
